// File: rtl/cast128_sched_if.sv
// rtl/cast128_sched_if.sv - job request / response port of the CAST-128 sequencer
interface cast128_sched_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_key_load;
  logic         req_data_en;
  logic         req_en_de;
  logic [127:0] req_key;
  logic [63:0]  req_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_data;
  logic         rsp_err;

  modport master (
    output req_valid, req_key_load, req_data_en, req_en_de, req_key, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_key_load, req_data_en, req_en_de, req_key, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/cast128_sched.sv
// rtl/cast128_sched.sv - sequences key/block jobs into the CAST-128 core with timeout
module cast128_sched #(
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8
) (
  input  logic                  clk,
  input  logic                  nreset,
  cast128_sched_if.slave        bus,
  output logic                  key_loaded,
  output logic                  core_key_rdy,
  output logic                  core_data_rdy,
  output logic                  core_en_de,
  output logic [127:0]          core_key_in,
  output logic [63:0]           core_data_in,
  input  logic                  core_busy,
  input  logic                  core_key_valid,
  input  logic                  core_data_valid,
  input  logic [63:0]           core_data_out
);

  typedef enum logic [2:0] {
    IDLE, KEY_START, KEY_WAIT, DATA_START, DATA_WAIT, RESP
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] timer;
  logic            key_first;
  logic            job_data_en;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [63:0]     rsp_data_q;
  logic [127:0]    key_q;
  logic [63:0]     data_q;
  logic            en_de_q;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign core_key_in   = key_q;
  assign core_data_in  = data_q;
  assign core_en_de    = en_de_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      timer         <= '0;
      key_first     <= 1'b0;
      job_data_en   <= 1'b0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_data_q    <= '0;
      key_q         <= '0;
      data_q        <= '0;
      en_de_q       <= 1'b0;
      key_loaded    <= 1'b0;
      core_key_rdy  <= 1'b0;
      core_data_rdy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            key_q       <= bus.req_key;
            data_q      <= bus.req_data;
            en_de_q     <= bus.req_en_de;
            job_data_en <= bus.req_data_en;
            if (bus.req_key_load) begin
              state <= KEY_START;
            end else if (bus.req_data_en && key_loaded) begin
              state <= DATA_START;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              state       <= RESP;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        KEY_START: begin
          if (!core_busy) begin
            core_key_rdy <= 1'b1;
            key_loaded   <= 1'b0;
            timer        <= '0;
            key_first    <= 1'b1;
            state        <= KEY_WAIT;
          end
        end
        KEY_WAIT: begin
          // key_valid may still be high from the previous key during the rdy cycle
          core_key_rdy <= 1'b0;
          key_first    <= 1'b0;
          timer        <= timer + TO_W'(1);
          if (!key_first && core_key_valid && !core_busy) begin
            key_loaded <= 1'b1;
            if (job_data_en) begin
              state <= DATA_START;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_data_q  <= '0;
              state       <= RESP;
            end
          end else if (timer == TO_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            key_loaded  <= 1'b0;
            state       <= RESP;
          end
        end
        DATA_START: begin
          if (!core_busy) begin
            core_data_rdy <= 1'b1;
            timer         <= '0;
            state         <= DATA_WAIT;
          end
        end
        DATA_WAIT: begin
          core_data_rdy <= 1'b0;
          timer         <= timer + TO_W'(1);
          if (core_data_valid) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= core_data_out;
            state       <= RESP;
          end else if (timer == TO_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            key_loaded  <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cast128_sched.sv
// tb/tb_cast128_sched.sv - directed self-checking bench for cast128_sched
module tb_cast128_sched;
  localparam int TIMEOUT  = 200;
  localparam int KEY_LAT  = 12;
  localparam int DATA_LAT = 8;
  localparam logic [127:0] KEY = 128'h0123456712345678234567893456789A;
  localparam logic [63:0]  PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0]  CT  = 64'h238B4FE5847E44B2;

  logic         clk = 1'b0;
  logic         nreset = 1'b1;
  logic         key_loaded, core_key_rdy, core_data_rdy, core_en_de;
  logic [127:0] core_key_in;
  logic [63:0]  core_data_in;
  logic         core_busy = 1'b0;
  logic         core_key_valid = 1'b0;
  logic         core_data_valid = 1'b0;
  logic [63:0]  core_data_out = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int key_pulses = 0;
  int data_pulses = 0;
  logic hang = 1'b0;

  cast128_sched_if bus();

  cast128_sched #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .nreset(nreset), .bus(bus),
    .key_loaded(key_loaded), .core_key_rdy(core_key_rdy), .core_data_rdy(core_data_rdy),
    .core_en_de(core_en_de), .core_key_in(core_key_in), .core_data_in(core_data_in),
    .core_busy(core_busy), .core_key_valid(core_key_valid),
    .core_data_valid(core_data_valid), .core_data_out(core_data_out)
  );

  always #5 clk = ~clk;

  // Stand-in for the cipher core: knows only the reference vector pair
  logic [127:0] mkey = '0;
  int kcnt = 0;
  int dcnt = 0;

  function automatic logic [63:0] core_f(input logic [127:0] k, input logic e, input logic [63:0] d);
    if (k == KEY && !e && d == PT) return CT;
    if (k == KEY && e && d == CT) return PT;
    return ~d;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_key_rdy) key_pulses <= key_pulses + 1;
    if (core_data_rdy) data_pulses <= data_pulses + 1;
    core_data_valid <= 1'b0;
    if (core_key_rdy) begin
      core_busy      <= 1'b1;
      core_key_valid <= 1'b0;
      mkey           <= core_key_in;
      kcnt           <= KEY_LAT;
    end else if (kcnt != 0) begin
      kcnt <= kcnt - 1;
      if (kcnt == 1) begin
        core_busy      <= 1'b0;
        core_key_valid <= 1'b1;
      end
    end
    if (core_data_rdy) begin
      core_busy <= 1'b1;
      dcnt      <= DATA_LAT;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        core_busy <= 1'b0;
        if (!hang) begin
          core_data_valid <= 1'b1;
          core_data_out   <= core_f(mkey, core_en_de, core_data_in);
        end
      end
    end
  end

  task automatic start_job(input logic kl, input logic de, input logic ed,
                           input logic [127:0] k, input logic [63:0] d);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_req_ready got=%b want=1", bus.req_ready);
    end
    bus.req_key_load = kl;
    bus.req_data_en  = de;
    bus.req_en_de    = ed;
    bus.req_key      = k;
    bus.req_data     = d;
    bus.req_valid    = 1'b1;
    @(negedge clk);
    bus.req_valid    = 1'b0;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 1;
    while (bus.rsp_valid !== 1'b1 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, key_loaded, core_key_rdy,
         core_data_rdy, core_en_de} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0", {bus.req_ready, bus.rsp_valid, bus.rsp_err,
               key_loaded, core_key_rdy, core_data_rdy, core_en_de});
    end
    total++;
    if (bus.rsp_data !== 64'h0 || core_key_in !== 128'h0 || core_data_in !== 64'h0) begin
      bad++;
      $display("FAIL reset_buses got=%h/%h/%h want=0", bus.rsp_data, core_key_in, core_data_in);
    end
    nreset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_idle_ready got=%b want=1", bus.req_ready);
    end
  endtask

  task automatic test_no_key();
    int k0 = key_pulses;
    int d0 = data_pulses;
    int c;
    start_job(1'b0, 1'b1, 1'b0, KEY, PT);
    wait_rsp(c);
    total++;
    if (c != 1) begin bad++; $display("FAIL nokey_latency got=%0d want=1", c); end
    total++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 64'h0) begin
      bad++;
      $display("FAIL nokey_rsp got=%b/%h want=1/0", bus.rsp_err, bus.rsp_data);
    end
    total++;
    if (key_pulses != k0 || data_pulses != d0) begin
      bad++;
      $display("FAIL nokey_pulses got=%0d/%0d want=0/0", key_pulses - k0, data_pulses - d0);
    end
    ack_rsp();
  endtask

  task automatic test_key_encrypt();
    int k0 = key_pulses;
    int d0 = data_pulses;
    int c;
    start_job(1'b1, 1'b1, 1'b0, KEY, PT);
    wait_rsp(c);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== CT || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL enc_rsp got=%b/%h/%b want=1/%h/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err, CT);
    end
    total++;
    if (key_pulses - k0 != 1 || data_pulses - d0 != 1) begin
      bad++;
      $display("FAIL enc_pulses got=%0d/%0d want=1/1", key_pulses - k0, data_pulses - d0);
    end
    total++;
    if (key_loaded !== 1'b1) begin bad++; $display("FAIL enc_key_loaded got=%b want=1", key_loaded); end
    total++;
    if (core_key_in !== KEY || core_data_in !== PT || core_en_de !== 1'b0) begin
      bad++;
      $display("FAIL enc_core_in got=%h/%h/%b want=%h/%h/0", core_key_in, core_data_in, core_en_de, KEY, PT);
    end
    ack_rsp();
  endtask

  task automatic test_decrypt();
    int k0 = key_pulses;
    int d0 = data_pulses;
    int c;
    start_job(1'b0, 1'b1, 1'b1, 128'h0, CT);
    wait_rsp(c);
    total++;
    if (bus.rsp_data !== PT || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL dec_rsp got=%h/%b want=%h/0", bus.rsp_data, bus.rsp_err, PT);
    end
    total++;
    if (key_pulses != k0 || data_pulses - d0 != 1) begin
      bad++;
      $display("FAIL dec_pulses got=%0d/%0d want=0/1", key_pulses - k0, data_pulses - d0);
    end
    ack_rsp();
  endtask

  task automatic test_key_only();
    int k0 = key_pulses;
    int d0 = data_pulses;
    int c;
    start_job(1'b1, 1'b0, 1'b0, KEY, 64'hFFFF_0000_FFFF_0000);
    wait_rsp(c);
    total++;
    if (bus.rsp_data !== 64'h0 || bus.rsp_err !== 1'b0 || key_loaded !== 1'b1) begin
      bad++;
      $display("FAIL keyonly_rsp got=%h/%b/%b want=0/0/1", bus.rsp_data, bus.rsp_err, key_loaded);
    end
    total++;
    if (key_pulses - k0 != 1 || data_pulses != d0) begin
      bad++;
      $display("FAIL keyonly_pulses got=%0d/%0d want=1/0", key_pulses - k0, data_pulses - d0);
    end
    ack_rsp();
  endtask

  task automatic test_back_pressure();
    int c;
    int errs = 0;
    start_job(1'b0, 1'b1, 1'b0, 128'h0, PT);
    wait_rsp(c);
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== CT || bus.req_ready !== 1'b0) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL bp_hold got=%0d bad cycles want=0 (last %b/%h/%b)", errs,
               bus.rsp_valid, bus.rsp_data, bus.req_ready);
    end
    ack_rsp();
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got=%b/%b want=0/1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_timeout();
    int p = -1;
    int r = -1;
    int n = 0;
    hang = 1'b1;
    start_job(1'b0, 1'b1, 1'b1, 128'h0, CT);
    while (r < 0 && n < 1000) begin
      if (core_data_rdy === 1'b1 && p < 0) p = cyc;
      if (bus.rsp_valid === 1'b1) r = cyc;
      else @(negedge clk);
      n++;
    end
    total++;
    if (p < 0 || r - p != TIMEOUT) begin
      bad++;
      $display("FAIL timeout_delay got=%0d want=%0d", r - p, TIMEOUT);
    end
    total++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 64'h0 || key_loaded !== 1'b0) begin
      bad++;
      $display("FAIL timeout_rsp got=%b/%h/%b want=1/0/0", bus.rsp_err, bus.rsp_data, key_loaded);
    end
    hang = 1'b0;
    ack_rsp();
  endtask

  task automatic test_reset_mid_job();
    int n = 0;
    int stray = 0;
    int c;
    start_job(1'b1, 1'b1, 1'b0, KEY, PT);
    while (core_key_rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    nreset = 1'b0;
    #1;
    total++;
    if ({bus.req_ready, bus.rsp_valid, key_loaded, core_key_rdy, core_data_rdy} !== 5'b0 ||
        core_key_in !== 128'h0 || core_data_in !== 64'h0) begin
      bad++;
      $display("FAIL midreset_outputs got=%b/%h want=0/0",
               {bus.req_ready, bus.rsp_valid, key_loaded, core_key_rdy, core_data_rdy}, core_key_in);
    end
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid !== 1'b0) stray++;
      @(negedge clk);
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL midreset_no_rsp got=%0d want=0", stray); end
    start_job(1'b1, 1'b1, 1'b0, KEY, PT);
    wait_rsp(c);
    total++;
    if (bus.rsp_data !== CT || bus.rsp_err !== 1'b0 || key_loaded !== 1'b1) begin
      bad++;
      $display("FAIL midreset_rejob got=%h/%b/%b want=%h/0/1", bus.rsp_data, bus.rsp_err, key_loaded, CT);
    end
    ack_rsp();
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_key_load = 1'b0;
    bus.req_data_en  = 1'b0;
    bus.req_en_de    = 1'b0;
    bus.req_key      = '0;
    bus.req_data     = '0;
    bus.rsp_ready    = 1'b0;
    #1;
    test_reset();
    test_no_key();
    test_key_encrypt();
    test_decrypt();
    test_key_only();
    test_back_pressure();
    test_timeout();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
